// File: rtl/zoom_sequencer.sv
// Digital-zoom sequencer: turns zoom button edges into scaling-engine launches and
// commits the new output dimensions only at a frame boundary.
module zoom_sequencer #(
    parameter int BASE_W         = 160,
    parameter int BASE_H         = 120,
    parameter int RESET_LEVEL    = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ZOOM_IN,
    input  logic       ZOOM_OUT,
    input  logic       FRAME_START,
    input  logic       ALGO_DONE,
    output logic       ALGO_START,
    output logic [1:0] ALGO_LEVEL,
    output logic       ALGO_DIR,
    output logic [9:0] IMG_WIDTH_OUT,
    output logic [8:0] IMG_HEIGHT_OUT,
    output logic [1:0] ZOOM_LEVEL,
    output logic       BUSY,
    output logic       ERR_LIMIT,
    output logic       ERR_TIMEOUT
);

    localparam int               CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       RESET_LVL = 2'(RESET_LEVEL);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_DONE  = 2'd1,
        WAIT_FRAME = 2'd2
    } state_t;

    // Level L scales the base size by 2^L / 4, so level 2 is the 1x image.
    function automatic logic [9:0] level_width(input logic [1:0] lvl);
        logic [31:0] w;
        w = (32'(BASE_W) << lvl) >> 2'd2;
        return w[9:0];
    endfunction

    function automatic logic [8:0] level_height(input logic [1:0] lvl);
        logic [31:0] h;
        h = (32'(BASE_H) << lvl) >> 2'd2;
        return h[8:0];
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             prev_in_r, prev_out_r;
    logic [1:0]       zoom_level_r, zoom_level_s;
    logic [1:0]       algo_level_r, algo_level_s;
    logic             algo_dir_r, algo_dir_s;
    logic             algo_start_r, algo_start_s;
    logic             busy_r, busy_s;
    logic             err_limit_r, err_limit_s;
    logic             err_timeout_r, err_timeout_s;
    logic [9:0]       img_w_r, img_w_s;
    logic [8:0]       img_h_r, img_h_s;
    logic             in_edge_s, out_edge_s;

    assign in_edge_s  = ZOOM_IN  & ~prev_in_r;
    assign out_edge_s = ZOOM_OUT & ~prev_out_r;

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        zoom_level_s  = zoom_level_r;
        algo_level_s  = algo_level_r;
        algo_dir_s    = algo_dir_r;
        algo_start_s  = 1'b0;
        busy_s        = busy_r;
        err_limit_s   = 1'b0;
        err_timeout_s = 1'b0;
        img_w_s       = img_w_r;
        img_h_s       = img_h_r;
        case (state_r)
            IDLE: begin
                if (in_edge_s && out_edge_s) begin
                    state_s = IDLE;
                end else if (in_edge_s) begin
                    if (zoom_level_r == 2'd3) begin
                        err_limit_s = 1'b1;
                    end else begin
                        algo_level_s = zoom_level_r + 2'd1;
                        algo_dir_s   = 1'b1;
                        algo_start_s = 1'b1;
                        busy_s       = 1'b1;
                        cnt_s        = '0;
                        state_s      = WAIT_DONE;
                    end
                end else if (out_edge_s) begin
                    if (zoom_level_r == 2'd0) begin
                        err_limit_s = 1'b1;
                    end else begin
                        algo_level_s = zoom_level_r - 2'd1;
                        algo_dir_s   = 1'b0;
                        algo_start_s = 1'b1;
                        busy_s       = 1'b1;
                        cnt_s        = '0;
                        state_s      = WAIT_DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_DONE: begin
                cnt_s = cnt_r + CNT_W'(1);
                // A DONE coincident with our own launch pulse is stale and ignored.
                if (ALGO_DONE && !algo_start_r) begin
                    state_s = WAIT_FRAME;
                end else if (cnt_r == CNT_LAST) begin
                    state_s       = IDLE;
                    err_timeout_s = 1'b1;
                    busy_s        = 1'b0;
                    algo_level_s  = zoom_level_r;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            WAIT_FRAME: begin
                if (FRAME_START) begin
                    zoom_level_s = algo_level_r;
                    img_w_s      = level_width(algo_level_r);
                    img_h_s      = level_height(algo_level_r);
                    busy_s       = 1'b0;
                    state_s      = IDLE;
                end else begin
                    state_s = WAIT_FRAME;
                end
            end
            default: begin
                state_s      = IDLE;
                busy_s       = 1'b0;
                algo_level_s = zoom_level_r;
                cnt_s        = '0;
            end
        endcase
    end

    // State and output registers; button history keeps tracking inputs during reset.
    always_ff @(posedge CLK) begin
        prev_in_r  <= ZOOM_IN;
        prev_out_r <= ZOOM_OUT;
        if (RST) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            zoom_level_r  <= RESET_LVL;
            algo_level_r  <= RESET_LVL;
            algo_dir_r    <= 1'b0;
            algo_start_r  <= 1'b0;
            busy_r        <= 1'b0;
            err_limit_r   <= 1'b0;
            err_timeout_r <= 1'b0;
            img_w_r       <= level_width(RESET_LVL);
            img_h_r       <= level_height(RESET_LVL);
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            zoom_level_r  <= zoom_level_s;
            algo_level_r  <= algo_level_s;
            algo_dir_r    <= algo_dir_s;
            algo_start_r  <= algo_start_s;
            busy_r        <= busy_s;
            err_limit_r   <= err_limit_s;
            err_timeout_r <= err_timeout_s;
            img_w_r       <= img_w_s;
            img_h_r       <= img_h_s;
        end
    end

    assign ALGO_START     = algo_start_r;
    assign ALGO_LEVEL     = algo_level_r;
    assign ALGO_DIR       = algo_dir_r;
    assign IMG_WIDTH_OUT  = img_w_r;
    assign IMG_HEIGHT_OUT = img_h_r;
    assign ZOOM_LEVEL     = zoom_level_r;
    assign BUSY           = busy_r;
    assign ERR_LIMIT      = err_limit_r;
    assign ERR_TIMEOUT    = err_timeout_r;

endmodule
